// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Byte stream: 16-bit word-count header, then MSB-first 32-bit words.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [DATA_W-1:0] im_wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]   MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [15:0]     count;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift;
    logic [ADDR_W:0] wl;
    logic [ADDR_W:0] wl_inc;
    logic [15:0]     hdr_count;
    logic            accept;
    logic            start_ok;
    logic            word_done;
    logic            last_word;

    assign accept    = byte_valid && byte_ready;
    assign hdr_count = {count[15:8], byte_in};
    assign wl_inc    = wl + WL_ONE;
    assign last_word = ({{(15 - ADDR_W){1'b0}}, wl_inc} == count);
    assign word_done = accept && (state == S_DATA) && (byte_cnt == 2'd3);
    assign start_ok  = start && ((state == S_IDLE) ||
                                 (state == S_DONE) ||
                                 (state == S_ERR));

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_HDR0;
            end
            S_HDR0: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) state_nx = S_HDR1;
            end
            S_HDR1: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    if (hdr_count == 16'd0)
                        state_nx = S_DONE;
                    else if ({1'b0, hdr_count} > MAX_WORDS)
                        state_nx = S_ERR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_done && last_word) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_nx = S_HDR0;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nx = S_HDR0;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            wl         <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
        end else begin
            state    <= state_nx;
            im_wr_en <= 1'b0;
            if (start_ok) begin
                count      <= '0;
                byte_cnt   <= '0;
                shift      <= '0;
                wl         <= '0;
                im_wr_addr <= '0;
            end
            if (accept) begin
                unique case (state)
                    S_HDR0: count[15:8] <= byte_in;
                    S_HDR1: count[7:0]  <= byte_in;
                    S_DATA: begin
                        shift    <= {shift[15:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end
            // Strobe lands the cycle after the 4th byte; address is the pre-increment count.
            if (word_done) begin
                im_wr_en   <= 1'b1;
                im_wr_data <= DATA_W'({shift, byte_in});
                im_wr_addr <= wl[ADDR_W-1:0];
                wl         <= wl_inc;
            end
        end
    end

    assign words_loaded = wl;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
// Writes are logged at negedge and compared to hand-computed streams.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_wr_en;
    logic [9:0]  im_wr_addr;
    logic [31:0] im_wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    imem_loader #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .im_wr_en     (im_wr_en),
        .im_wr_addr   (im_wr_addr),
        .im_wr_data   (im_wr_data),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_we_cyc = 0;
    int rel_bad = 0;
    logic [9:0]  addr_q[$];
    logic [31:0] data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (im_wr_en) begin
            addr_q.push_back(im_wr_addr);
            data_q.push_back(im_wr_data);
            last_we_cyc = cyc;
            if (!cpu_reset) rel_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        g = 0;
        while (!byte_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("ready_timeout", 32'(g), 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        addr_q.delete();
        data_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(done || error) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("end_wait", 32'(g < 5000), 32'd1);
    endtask

    function automatic logic [31:0] big_word(input int i);
        return (32'(i) * 32'h0001_0001) ^ 32'h5A00_0000;
    endfunction

    task automatic two_word_load(input int gap, input string nm);
        pulse_start();
        chk({nm, "_cpu_rst"}, 32'(cpu_reset), 32'd1);
        send_byte(8'h00, gap);
        send_byte(8'h02, gap);
        send_word(32'h2008_0005, gap);
        send_word(32'h0000_0008, gap);
        idle_bus();
        wait_end();
        chk({nm, "_nwr"}, 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            chk({nm, "_a0"}, 32'(addr_q[0]), 32'd0);
            chk({nm, "_d0"}, data_q[0], 32'h2008_0005);
            chk({nm, "_a1"}, 32'(addr_q[1]), 32'd1);
            chk({nm, "_d1"}, data_q[1], 32'h0000_0008);
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_cpu"}, 32'(cpu_reset), 32'd0);
        chk({nm, "_wl"}, 32'(words_loaded), 32'd2);
        chk({nm, "_lat"}, 32'(cyc - last_we_cyc), 32'd1);
    endtask

    initial begin
        int errs;
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu", 32'(cpu_reset), 32'd1);
        chk("rst_rdy", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(im_wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Stray valid in IDLE must not be consumed.
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        @(negedge clk);
        chk("idle_rdy", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;

        two_word_load(0, "norm");
        two_word_load(1, "gap");

        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        idle_bus();
        wait_end();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_nwr", 32'(addr_q.size()), 32'd0);
        chk("zero_wl", 32'(words_loaded), 32'd0);

        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        idle_bus();
        wait_end();
        chk("ovf_err", 32'(error), 32'd1);
        chk("ovf_cpu", 32'(cpu_reset), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_rdy", 32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("ovf_nwr", 32'(addr_q.size()), 32'd0);

        pulse_start();
        chk("max_err_clr", 32'(error), 32'd0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) send_word(big_word(i), 0);
        idle_bus();
        wait_end();
        chk("max_done", 32'(done), 32'd1);
        chk("max_wl", 32'(words_loaded), 32'd1024);
        chk("max_nwr", 32'(addr_q.size()), 32'd1024);
        errs = 0;
        if (addr_q.size() == 1024) begin
            for (int i = 0; i < 1024; i++)
                if (addr_q[i] != 10'(i) || data_q[i] != big_word(i)) errs++;
            chk("max_last_a", 32'(addr_q[1023]), 32'd1023);
        end
        chk("max_seq", 32'(errs), 32'd0);

        pulse_start();
        chk("rl_cpu", 32'(cpu_reset), 32'd1);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_wl", 32'(words_loaded), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rl_ign_busy", 32'(busy), 32'd1);
        chk("rl_ign_rdy", 32'(byte_ready), 32'd1);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        idle_bus();
        wait_end();
        chk("rl_nwr", 32'(addr_q.size()), 32'd1);
        if (addr_q.size() == 1) begin
            chk("rl_a0", 32'(addr_q[0]), 32'd0);
            chk("rl_d0", data_q[0], 32'hAABB_CCDD);
        end
        chk("rl_done2", 32'(done), 32'd1);
        chk("rl_wl2", 32'(words_loaded), 32'd1);

        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wl", 32'(words_loaded), 32'd0);
        chk("mid_rdy", 32'(byte_ready), 32'd0);
        chk("mid_cpu", 32'(cpu_reset), 32'd1);
        chk("mid_we", 32'(im_wr_en), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_nwr", 32'(addr_q.size()), 32'd1);
        if (addr_q.size() == 1) begin
            chk("mid_a0", 32'(addr_q[0]), 32'd0);
            chk("mid_d0", data_q[0], 32'h1122_3344);
        end
        chk("mid_done", 32'(done), 32'd0);

        chk("early_release", 32'(rel_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader. Writes instruction words into the instruction memory's write port while the core is held in reset. This is the write side of the instruction-memory interface that the core's fetch path reads.
- It accepts a byte stream over a valid/ready handshake. The stream is a 16-bit word-count header followed by 32-bit words, each sent MSB byte first.
- Words are written to consecutive word addresses starting at 0. The PC is word-indexed and increments by 1.
- When the load completes, the block releases the core's reset.

Parameters:
ADDR_W, 10, instruction-memory word address width (depth 2^ADDR_W = 1024 words)
DATA_W, 32, instruction word width (fixed at 4 bytes)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE, DONE, ERR
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte this cycle
im_wr_en  output  1  one-cycle instruction-memory write strobe
im_wr_addr  output  ADDR_W  word address for the write
im_wr_data  output  DATA_W  assembled instruction word
cpu_reset  output  1  holds the core in reset; high unless DONE
busy  output  1  load in progress (HDR0/HDR1/DATA/FLUSH)
done  output  1  load completed; held until the next start or reset
error  output  1  header word count exceeded 2^ADDR_W; held until the next start or reset
words_loaded  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset values:
  - byte_ready=0, im_wr_en=0, im_wr_addr=0, im_wr_data=0
  - cpu_reset=1, busy=0, done=0, error=0, words_loaded=0
  - state=IDLE, byte counter=0, count register=0
- Byte acceptance: a byte is accepted on a posedge where byte_valid && byte_ready. A byte held with byte_ready=0 is not consumed; the sender holds it.
- byte_ready: equals 1 exactly in HDR0, HDR1 and DATA. It is a registered/state decode and never depends combinationally on byte_valid.
- States:
  - IDLE: start=1 -> HDR0. Clears words_loaded, im_wr_addr, byte counter, done, error.
  - HDR0: on accept, count[15:8]=byte -> HDR1.
  - HDR1: on accept, count[7:0]=byte. Then:
    - count=0 -> DONE.
    - count>2^ADDR_W -> ERR.
    - otherwise -> DATA.
  - DATA: accepted bytes are shifted into the word MSB first; the byte counter counts 0..3.
    - On the 4th byte, the next cycle has im_wr_en=1, im_wr_data=assembled word, im_wr_addr=words_loaded (old value).
    - On that same next edge, words_loaded increments; im_wr_addr advances after the strobe.
    - If this was not the last word, stay in DATA with byte_ready still 1 (back-to-back bytes, no stall).
    - If it was the last word (words_loaded+1==count), go to FLUSH.
  - FLUSH: byte_ready=0 and im_wr_en=1 for this single cycle. -> DONE.
  - DONE: done=1, cpu_reset=0, busy=0. start=1 -> HDR0, re-asserting cpu_reset=1 and clearing done, words_loaded, im_wr_addr.
  - ERR: error=1, cpu_reset=1, no writes. start=1 -> HDR0, clearing error.
- Write timing: im_wr_en is high for exactly one cycle per word, one cycle after the word's 4th byte is accepted.
- Latency after the last write: the last im_wr_en cycle is followed by done=1 and cpu_reset=0 on the next cycle. The core therefore never leaves reset before the final word is in memory.
- count=2^ADDR_W is legal: the last address is 2^ADDR_W-1 and words_loaded ends at 2^ADDR_W (no wrap).
- start while busy is ignored.
- Stray byte_valid in IDLE/DONE/ERR is not accepted (byte_ready=0).
- Reset mid-load: all outputs and state return to reset values next cycle. The partial word is discarded; memory words already written are not touched.
- Reset has priority over start in the same cycle.

Test Plan:
- Reset: assert reset 2 cycles -> cpu_reset=1, byte_ready=0, im_wr_en=0, done=0, words_loaded=0.
- Normal 2-word load: start; bytes 00 02 | 20 08 00 05 | 00 00 00 08, byte_valid continuous ->
  - im_wr_en pulses at addr 0 with 0x20080005, then at addr 1 with 0x00000008.
  - Next cycle done=1, cpu_reset=0, words_loaded=2.
- Backpressure/gaps: same stream with byte_valid toggling every other cycle -> identical writes and data; exactly 2 strobes; no byte lost or duplicated.
- Zero and max count:
  - Header 00 00 -> DONE immediately after HDR1, no im_wr_en.
  - Header 04 01 (1025) -> error=1, cpu_reset=1, no writes.
  - Header 04 00 accepted; last write at addr 1023, words_loaded=1024.
- Reset mid-word: after header 00 03 and 6 data bytes, assert reset -> only addr 0 written; state IDLE, words_loaded=0.
- Reload: from DONE, pulse start and stream 00 01 | AA BB CC DD -> cpu_reset=1 during load; write 0xAABBCCDD at addr 0; done=1 again; start during DATA is ignored.
